// File: rtl/align_link_pkg.sv
// Shared link constants, framer state encoding and output word record.
// Latency: n/a (definitions only).
// Backpressure: n/a. The RX aligner imports the same ALIGN/IDLE constants.
package align_link_pkg;

  localparam int          LINK_W     = 32;
  localparam logic [31:0] ALIGN_WORD = 32'hEB94_BDA3;
  localparam logic [31:0] IDLE_WORD  = 32'h0707_0707;

  typedef enum logic [1:0] {
    S_OFF      = 2'd0,
    S_PREAMBLE = 2'd1,
    S_RUN      = 2'd2,
    S_HDR      = 2'd3
  } framer_state_e;

  // Registered word presented to the SERDES, with its side flags.
  typedef struct packed {
    logic              vld;
    logic              hdr;
    logic              pre;
    logic [LINK_W-1:0] dat;
  } tx_word_t;

  // A configured length of zero still produces one word.
  function automatic logic [7:0] at_least_one8(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

  function automatic logic [3:0] at_least_one4(input logic [3:0] v);
    return (v == 4'd0) ? 4'd1 : v;
  endfunction

endpackage

// File: rtl/sync_pulse_2ff.sv
// Two-flop synchronizer for an async level/pulse, then rising-edge detect.
// Latency: o_pulse rises 3 clk after i_async is first sampled high; one cycle wide.
// Backpressure: none.
// Ports: clk, rst (sync, active-high), i_async (async in), o_pulse (registered 1-cycle pulse).
module sync_pulse_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sync3_q, sync3_d;
  logic pulse_q, pulse_d;

  always_comb begin
    sync1_d = i_async;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    // Edge taken between the last metastability stage and its delayed copy.
    pulse_d = sync2_q & ~sync3_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      pulse_q <= pulse_d;
    end
  end

  assign o_pulse = pulse_q;

endmodule

// File: rtl/tx_align_framer_ms.sv
// TX framer: ALIGN preamble, periodic ALIGN header bursts, IDLE fill, payload pass-through.
// Latency: payload accepted in cycle N appears on o_tx_data in N+1.
// Backpressure: o_tx_ready low outside S_RUN, during resync and while tx_reset_done is low.
// Ports: clk, rst; tx_reset_done, i_resync_req; cfg_preamble_len/hdr_period/hdr_burst;
//        i_tx_data/i_tx_valid/o_tx_ready payload handshake; o_tx_data/o_tx_valid/o_is_header/
//        o_preamble_active registered word out; o_collision_cnt saturating ALIGN-in-payload count.
module tx_align_framer_ms
  import align_link_pkg::*;
#(
  parameter int W = LINK_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tx_reset_done,
  input  logic         i_resync_req,
  input  logic [7:0]   cfg_preamble_len,
  input  logic [15:0]  cfg_hdr_period,
  input  logic [3:0]   cfg_hdr_burst,
  input  logic [W-1:0] i_tx_data,
  input  logic         i_tx_valid,
  output logic         o_tx_ready,
  output logic [W-1:0] o_tx_data,
  output logic         o_tx_valid,
  output logic         o_is_header,
  output logic         o_preamble_active,
  output logic [15:0]  o_collision_cnt
);

  logic resync_pulse;

  sync_pulse_2ff u_resync_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (i_resync_req),
    .o_pulse (resync_pulse)
  );

  framer_state_e state_q, state_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;
  logic [7:0]  pre_len_q, pre_len_d;
  logic [15:0] period_cnt_q, period_cnt_d;
  logic [15:0] period_len_q, period_len_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic [3:0]  burst_len_q, burst_len_d;
  logic [15:0] coll_q, coll_d;
  tx_word_t    out_q, out_d;
  logic        accept;

  // rst also blocks the handshake so nothing is consumed while the block is held.
  assign o_tx_ready = !rst && tx_reset_done && (state_q == S_RUN) && !resync_pulse;
  assign accept     = o_tx_ready && i_tx_valid;

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    pre_len_d    = pre_len_q;
    period_cnt_d = period_cnt_q;
    period_len_d = period_len_q;
    burst_cnt_d  = burst_cnt_q;
    burst_len_d  = burst_len_q;
    coll_d       = coll_q;
    out_d        = '0;

    if (accept && (i_tx_data == ALIGN_WORD) && (coll_q != 16'hFFFF)) begin
      coll_d = coll_q + 16'd1;
    end

    case (state_q)
      S_OFF: begin
        if (tx_reset_done) begin
          state_d   = S_PREAMBLE;
          pre_cnt_d = 8'd0;
          pre_len_d = at_least_one8(cfg_preamble_len);
        end
      end
      S_PREAMBLE: begin
        out_d = '{vld: 1'b1, hdr: 1'b1, pre: 1'b1, dat: ALIGN_WORD};
        if (pre_cnt_q == pre_len_q - 8'd1) begin
          state_d      = S_RUN;
          pre_cnt_d    = 8'd0;
          period_cnt_d = 16'd0;
          period_len_d = cfg_hdr_period;
        end else begin
          pre_cnt_d = pre_cnt_q + 8'd1;
        end
      end
      S_RUN: begin
        out_d.vld = 1'b1;
        out_d.dat = accept ? i_tx_data : IDLE_WORD;
        if ((period_len_q != 16'd0) && (period_cnt_q == period_len_q - 16'd1)) begin
          // Period wrap: reload both burst and period settings here.
          state_d      = S_HDR;
          period_cnt_d = 16'd0;
          period_len_d = cfg_hdr_period;
          burst_cnt_d  = 4'd0;
          burst_len_d  = at_least_one4(cfg_hdr_burst);
        end else if (period_cnt_q != 16'hFFFF) begin
          period_cnt_d = period_cnt_q + 16'd1;
        end
      end
      S_HDR: begin
        out_d = '{vld: 1'b1, hdr: 1'b1, pre: 1'b0, dat: ALIGN_WORD};
        if (burst_cnt_q == burst_len_q - 4'd1) begin
          state_d     = S_RUN;
          burst_cnt_d = 4'd0;
        end else begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end
      end
      default: state_d = S_OFF;
    endcase

    // Resync overrides any header due this cycle.
    if (resync_pulse && (state_q != S_OFF)) begin
      state_d      = S_PREAMBLE;
      pre_cnt_d    = 8'd0;
      pre_len_d    = at_least_one8(cfg_preamble_len);
      period_cnt_d = 16'd0;
      burst_cnt_d  = 4'd0;
    end

    // Losing the PCS drops the word in flight rather than holding it.
    if (!tx_reset_done) begin
      state_d      = S_OFF;
      out_d        = '0;
      pre_cnt_d    = 8'd0;
      period_cnt_d = 16'd0;
      burst_cnt_d  = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_OFF;
      pre_cnt_q    <= 8'd0;
      pre_len_q    <= 8'd0;
      period_cnt_q <= 16'd0;
      period_len_q <= 16'd0;
      burst_cnt_q  <= 4'd0;
      burst_len_q  <= 4'd0;
      coll_q       <= 16'd0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      pre_len_q    <= pre_len_d;
      period_cnt_q <= period_cnt_d;
      period_len_q <= period_len_d;
      burst_cnt_q  <= burst_cnt_d;
      burst_len_q  <= burst_len_d;
      coll_q       <= coll_d;
      out_q        <= out_d;
    end
  end

  assign o_tx_data         = out_q.dat;
  assign o_tx_valid        = out_q.vld;
  assign o_is_header       = out_q.hdr;
  assign o_preamble_active = out_q.pre;
  assign o_collision_cnt   = coll_q;

endmodule

// File: tb/tb_tx_align_framer_ms.sv
// Directed bench: table of per-cycle vectors plus hand sequences for bursts, resync and PCS drop.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: payload source holds data until o_tx_ready is seen high.
module tb_tx_align_framer_ms;
  import align_link_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_reset_done;
  logic        i_resync_req;
  logic [7:0]  cfg_preamble_len;
  logic [15:0] cfg_hdr_period;
  logic [3:0]  cfg_hdr_burst;
  logic [31:0] i_tx_data;
  logic        i_tx_valid;
  logic        o_tx_ready;
  logic [31:0] o_tx_data;
  logic        o_tx_valid;
  logic        o_is_header;
  logic        o_preamble_active;
  logic [15:0] o_collision_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tx_align_framer_ms dut (
    .clk               (clk),
    .rst               (rst),
    .tx_reset_done     (tx_reset_done),
    .i_resync_req      (i_resync_req),
    .cfg_preamble_len  (cfg_preamble_len),
    .cfg_hdr_period    (cfg_hdr_period),
    .cfg_hdr_burst     (cfg_hdr_burst),
    .i_tx_data         (i_tx_data),
    .i_tx_valid        (i_tx_valid),
    .o_tx_ready        (o_tx_ready),
    .o_tx_data         (o_tx_data),
    .o_tx_valid        (o_tx_valid),
    .o_is_header       (o_is_header),
    .o_preamble_active (o_preamble_active),
    .o_collision_cnt   (o_collision_cnt)
  );

  typedef struct {
    logic        rst, trd, vld;
    logic [31:0] dat;
    logic [7:0]  pl;
    logic [15:0] hp;
    logic [3:0]  hb;
    logic        e_rdy, e_vld, e_hdr, e_pre;
    logic [31:0] e_dat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic t, input logic v, input logic [31:0] d,
                     input logic [7:0] pl, input logic [15:0] hp, input logic [3:0] hb,
                     input logic er, input logic ev, input logic eh, input logic ep,
                     input logic [31:0] ed);
    vec_t x;
    x.rst = r; x.trd = t; x.vld = v; x.dat = d;
    x.pl = pl; x.hp = hp; x.hb = hb;
    x.e_rdy = er; x.e_vld = ev; x.e_hdr = eh; x.e_pre = ep; x.e_dat = ed;
    tbl.push_back(x);
  endtask

  task automatic do_reset(input logic [7:0] pl, input logic [15:0] hp, input logic [3:0] hb);
    rst = 1'b1;
    tx_reset_done = 1'b1;
    i_resync_req = 1'b0;
    i_tx_valid = 1'b0;
    i_tx_data = 32'd0;
    cfg_preamble_len = pl;
    cfg_hdr_period = hp;
    cfg_hdr_burst = hb;
    repeat (4) tick();
    rst = 1'b0;
  endtask

  // Leaves the bench at a point where o_tx_ready is high, or records a timeout.
  task automatic wait_ready(input string name, input int budget);
    int n;
    n = 0;
    i_tx_valid = 1'b0;
    #1;
    while (!o_tx_ready && n < budget) begin
      tick();
      #1;
      n++;
    end
    if (!o_tx_ready) chk({name, ".timeout"}, 32'(n), 32'(budget + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] nextv, prev_dat, e_word;
    logic        prev_acc, rdy, seen_run;
    int          pay_run, hdr_run, n, pre_n, idle_n, pay_out;

    // ---------------- reset state ----------------
    do_reset(8'd8, 16'd0, 4'd1);
    chk("rst.vld",  32'(o_tx_valid), 32'd0);
    chk("rst.dat",  o_tx_data, 32'd0);
    chk("rst.hdr",  32'(o_is_header), 32'd0);
    chk("rst.pre",  32'(o_preamble_active), 32'd0);
    chk("rst.coll", 32'(o_collision_cnt), 32'd0);
    chk("rst.rdy",  32'(o_tx_ready), 32'd0);

    // ---------------- table: preamble 8 then idle/payload ----------------
    add(0, 1, 0, 32'd0, 8'd8, 16'd0, 4'd1, 0, 0, 0, 0, 32'd0);
    for (int k = 0; k < 8; k++)
      add(0, 1, 0, 32'd0, 8'd8, 16'd0, 4'd1, 0, 1, 1, 1, ALIGN_WORD);
    add(0, 1, 0, 32'd0,         8'd8, 16'd0, 4'd1, 1, 1, 0, 0, IDLE_WORD);
    add(0, 1, 1, 32'h1234_5678, 8'd8, 16'd0, 4'd1, 1, 1, 0, 0, 32'h1234_5678);
    add(0, 1, 0, 32'd0,         8'd8, 16'd0, 4'd1, 1, 1, 0, 0, IDLE_WORD);
    add(0, 0, 1, 32'hAAAA_5555, 8'd8, 16'd0, 4'd1, 0, 0, 0, 0, 32'd0);
    // ---------------- table: all-zero config ----------------
    add(1, 1, 0, 32'd0, 8'd0, 16'd0, 4'd0, 0, 0, 0, 0, 32'd0);
    add(1, 1, 0, 32'd0, 8'd0, 16'd0, 4'd0, 0, 0, 0, 0, 32'd0);
    add(0, 1, 0, 32'd0, 8'd0, 16'd0, 4'd0, 0, 0, 0, 0, 32'd0);
    add(0, 1, 0, 32'd0, 8'd0, 16'd0, 4'd0, 0, 1, 1, 1, ALIGN_WORD);
    for (int k = 1; k <= 24; k++) begin
      logic v;
      v = ((k % 5) != 3);
      add(0, 1, v, 32'(k), 8'd0, 16'd0, 4'd0, 1, 1, 0, 0, v ? 32'(k) : IDLE_WORD);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      tx_reset_done = tbl[i].trd;
      i_tx_valid = tbl[i].vld;
      i_tx_data = tbl[i].dat;
      cfg_preamble_len = tbl[i].pl;
      cfg_hdr_period = tbl[i].hp;
      cfg_hdr_burst = tbl[i].hb;
      #1;
      chk($sformatf("tbl%0d.rdy", i), 32'(o_tx_ready), 32'(tbl[i].e_rdy));
      tick();
      chk($sformatf("tbl%0d.vld", i), 32'(o_tx_valid), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d.dat", i), o_tx_data, tbl[i].e_dat);
      chk($sformatf("tbl%0d.hdr", i), 32'(o_is_header), 32'(tbl[i].e_hdr));
      chk($sformatf("tbl%0d.pre", i), 32'(o_preamble_active), 32'(tbl[i].e_pre));
    end

    // ---------------- periodic headers 16/4 with continuous payload ----------------
    do_reset(8'd2, 16'd16, 4'd4);
    nextv = 32'd100; prev_acc = 1'b0; prev_dat = 32'd0; seen_run = 1'b0;
    pay_run = 0; hdr_run = 0; pay_out = 0;
    for (int c = 0; c < 120; c++) begin
      if (prev_acc) begin
        chk("hdr16.pay_dat", o_tx_data, prev_dat);
        chk("hdr16.pay_hdr", 32'(o_is_header), 32'd0);
        if (hdr_run > 0) chk("hdr16.burst_len", 32'(hdr_run), 32'd4);
        hdr_run = 0;
        pay_run++;
        pay_out++;
      end else if (seen_run) begin
        chk("hdr16.hdr_word", o_tx_data, ALIGN_WORD);
        chk("hdr16.hdr_flag", 32'(o_is_header), 32'd1);
        if (pay_run > 0) chk("hdr16.run_len", 32'(pay_run), 32'd16);
        pay_run = 0;
        hdr_run++;
      end
      i_tx_valid = 1'b1;
      i_tx_data = nextv;
      #1;
      rdy = o_tx_ready;
      tick();
      prev_acc = rdy;
      prev_dat = nextv;
      if (rdy) begin
        nextv = nextv + 32'd1;
        seen_run = 1'b1;
      end
    end
    chk("hdr16.no_loss", 32'(pay_out + (prev_acc ? 1 : 0)), nextv - 32'd100);
    i_tx_valid = 1'b0;

    // ---------------- payload equal to ALIGN_WORD ----------------
    do_reset(8'd1, 16'd0, 4'd1);
    wait_ready("coll", 10);
    for (int k = 0; k < 4; k++) begin
      e_word = (k == 2) ? 32'h0000_0001 : ALIGN_WORD;
      i_tx_valid = 1'b1;
      i_tx_data = e_word;
      #1;
      chk($sformatf("coll%0d.rdy", k), 32'(o_tx_ready), 32'd1);
      tick();
      chk($sformatf("coll%0d.dat", k), o_tx_data, e_word);
      chk($sformatf("coll%0d.hdr", k), 32'(o_is_header), 32'd0);
    end
    i_tx_valid = 1'b0;
    chk("coll.cnt", 32'(o_collision_cnt), 32'd3);

    // ---------------- resync mid header burst ----------------
    do_reset(8'd4, 16'd8, 4'd8);
    n = 0;
    while (!(o_tx_valid && o_is_header && !o_preamble_active) && n < 60) begin
      tick();
      n++;
    end
    chk("rsy.first_burst_seen", 32'(o_is_header && !o_preamble_active), 32'd1);
    i_resync_req = 1'b1;
    n = 0;
    while (!o_preamble_active && n < 20) begin
      tick();
      n++;
    end
    chk("rsy.edges_to_preamble", 32'(n), 32'd5);
    pre_n = 0;
    while (o_preamble_active && pre_n < 40) begin
      chk("rsy.pre_word", o_tx_data, ALIGN_WORD);
      pre_n++;
      tick();
    end
    chk("rsy.pre_len", 32'(pre_n), 32'd4);
    chk("rsy.first_run_word", o_tx_data, IDLE_WORD);
    idle_n = 0;
    while (!o_is_header && idle_n < 40) begin
      idle_n++;
      tick();
    end
    chk("rsy.period_restart", 32'(idle_n), 32'd8);
    i_resync_req = 1'b0;

    // ---------------- tx_reset_done drop mid payload ----------------
    do_reset(8'd2, 16'd0, 4'd1);
    wait_ready("drop", 10);
    for (int k = 0; k < 4; k++) begin
      i_tx_valid = 1'b1;
      i_tx_data = 32'hC000_0000 + 32'(k);
      tick();
      chk($sformatf("drop.pre%0d", k), o_tx_data, 32'hC000_0000 + 32'(k));
    end
    tx_reset_done = 1'b0;
    i_tx_data = 32'hDEAD_0000;
    #1;
    chk("drop.rdy_now", 32'(o_tx_ready), 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 2) i_tx_data = 32'hE000_0001;
      chk($sformatf("drop.vld%0d", k), 32'(o_tx_valid), 32'd0);
      chk($sformatf("drop.rdy%0d", k), 32'(o_tx_ready), 32'd0);
    end
    tx_reset_done = 1'b1;
    pre_n = 0;
    n = 0;
    tick();
    while (!(o_tx_valid && !o_is_header) && n < 20) begin
      if (o_preamble_active) pre_n++;
      tick();
      n++;
    end
    chk("drop.pre_len", 32'(pre_n), 32'd2);
    chk("drop.no_replay", o_tx_data, 32'hE000_0001);
    i_tx_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
